// File: rtl/bsa_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
//   bsa_state_t : controller state encoding (binary)
//   cnt_last()  : terminal bit-counter value for a given operand width
package bsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bsa_state_t;

  // Index of the last bit processed; RUN ends on the edge where cnt reaches it.
  function automatic int unsigned cnt_last(input int unsigned width);
    return width - 1;
  endfunction

endpackage

// File: rtl/bit_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder controller.
//   master : producer/consumer side (drives operands, accepts results)
//   slave  : controller side
// Signals: in_valid/in_ready, op_a, op_b, sub (operand channel);
//          out_valid/out_ready, sum, cout (result channel); busy (status).
interface bit_serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/fa_cell.sv
// Single full-adder bit slice, purely combinational.
//   s = a ^ b ^ ci, c = maj(a, b, ci)
//   BEHAV = 1 selects a behavioural model instead of the cell netlist.
module fa_cell #(
  parameter bit BEHAV = 1'b0
) (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b,
  input  logic ci
);

  if (BEHAV) begin : g_behav
    assign s = a ^ b ^ ci;
    assign c = (a & b) | (a & ci) | (b & ci);
  end else begin : g_cells
    xor3_10t u_xor (.y(s), .a(a), .b(b), .c(ci));
    maj3_6t  u_maj (.y(c), .a(a), .b(b), .c(ci));
  end

endmodule

// File: rtl/maj3_6t.sv
// Logic-level model of the 6-transistor three-input majority cell.
//   y = maj(a, b, c)
module maj3_6t (
  output logic y,
  input  logic a,
  input  logic b,
  input  logic c
);

  // c only matters when a and b disagree.
  assign y = (a & b) | (c & (a | b));

endmodule

// File: rtl/xor3_10t.sv
// Logic-level model of the 10-transistor three-input XOR cell.
//   y = a ^ b ^ c, built as the cell does: c steers between XOR(a,b)
//   and its complement.
module xor3_10t (
  output logic y,
  input  logic a,
  input  logic b,
  input  logic c
);

  logic ab_x;

  assign ab_x = a ^ b;
  assign y    = c ? ~ab_x : ab_x;

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: time-shares one fa_cell over WIDTH
// clocks, LSB first.
//   clk, rst_n : clock and async active-low reset
//   bus        : slave side of bit_serial_adder_ctrl_if (operand channel,
//                result channel, busy)
// Subtraction is A + ~B + 1; cout = 1 then means no borrow.
module bit_serial_adder_ctrl
  import bsa_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter bit          FA_BEHAV = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  bit_serial_adder_ctrl_if.slave        bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(cnt_last(WIDTH));

  bsa_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             fa_s, fa_c;

  // The one shared bit slice.
  fa_cell #(.BEHAV(FA_BEHAV)) u_fa (
    .s  (fa_s),
    .c  (fa_c),
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath next values.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_sh_d  = bus.op_a;
          b_sh_d  = bus.op_b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // New bit enters at the MSB; written as a shift so WIDTH = 1 works.
        sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        carry_d  = fa_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = sum_sh_d;
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs; handshake flags track the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Directed bench for bit_serial_adder_ctrl: WIDTH = 8 instance using the
// cell netlist, WIDTH = 1 instance using the behavioural bit slice.
module tb_bit_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bit_serial_adder_ctrl_if #(.WIDTH(W)) bus ();
  bit_serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

  bit_serial_adder_ctrl #(.WIDTH(W), .FA_BEHAV(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  bit_serial_adder_ctrl #(.WIDTH(1), .FA_BEHAV(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the WIDTH = 8 instance, starting and ending in IDLE.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [7:0] esum, input logic ecout,
                       input int hold);
    int lat;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.op_a     = 8'hA5;
    bus.op_b     = 8'h5A;
    bus.sub      = ~s;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(W));
    check({tag, "_sum"}, 32'(bus.sum), 32'(esum));
    check({tag, "_cout"}, 32'(bus.cout), 32'(ecout));
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_sum"}, 32'(bus.sum), 32'(esum));
      check({tag, "_hold_cout"}, 32'(bus.cout), 32'(ecout));
      check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_idle_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  logic [7:0] pa [3];
  logic [7:0] pb [3];
  logic       ps [3];
  logic [7:0] es [3];
  logic       ec [3];

  initial begin
    int acc, res, last_acc, last_res;
    logic pre;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.op_a     = '0;
    bus1.op_b     = '0;
    bus1.sub      = 1'b0;
    bus1.out_ready = 1'b0;

    // Reset held while inputs toggle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid  = ~bus.in_valid;
      bus.out_ready = ~bus.out_ready;
      bus.op_a      = 8'(i * 37 + 3);
      bus.op_b      = 8'(i * 11 + 9);
    end
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);

    // Add and subtract vectors.
    do_op("add_3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    do_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 0);
    do_op("sub_07_05", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 0);

    // Backpressure: five cycles with out_ready low in DONE.
    do_op("bp", 8'h9C, 8'h4B, 1'b0, 8'hE7, 1'b0, 5);

    // Reset at cnt = 3 aborts the operation.
    bus.op_a     = 8'hAA;
    bus.op_b     = 8'h55;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("mid_busy_before_rst", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_sum", 32'(bus.sum), 32'd0);
    check("mid_rst_cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mid_rst_no_valid", 32'(bus.out_valid), 32'd0);
    end
    do_op("after_abort", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0);

    // Back-to-back with in_valid held and out_ready high.
    pa[0] = 8'h12; pb[0] = 8'h34; ps[0] = 1'b0; es[0] = 8'h46; ec[0] = 1'b0;
    pa[1] = 8'h80; pb[1] = 8'h01; ps[1] = 1'b1; es[1] = 8'h7F; ec[1] = 1'b1;
    pa[2] = 8'hF0; pb[2] = 8'h20; ps[2] = 1'b0; es[2] = 8'h10; ec[2] = 1'b1;
    acc = 0;
    res = 0;
    last_acc = 0;
    last_res = 0;
    bus.out_ready = 1'b1;
    bus.op_a      = pa[0];
    bus.op_b      = pb[0];
    bus.sub       = ps[0];
    bus.in_valid  = 1'b1;
    for (int cyc = 0; cyc < 80 && res < 3; cyc++) begin
      pre = bus.in_ready && bus.in_valid;
      tick();
      if (pre) begin
        if (acc > 0) check("b2b_accept_gap", 32'(cyc - last_acc), 32'(W + 2));
        last_acc = cyc;
        acc++;
        if (acc < 3) begin
          bus.op_a = pa[acc];
          bus.op_b = pb[acc];
          bus.sub  = ps[acc];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        if (res < 3) begin
          check("b2b_sum", 32'(bus.sum), 32'(es[res]));
          check("b2b_cout", 32'(bus.cout), 32'(ec[res]));
        end
        if (res > 0) check("b2b_result_gap", 32'(cyc - last_res), 32'(W + 2));
        last_res = cyc;
        res++;
      end
    end
    check("b2b_accepts", 32'(acc), 32'd3);
    check("b2b_results", 32'(res), 32'd3);
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    tick();
    check("b2b_idle", 32'(bus.in_ready), 32'd1);

    // WIDTH = 1: one RUN cycle.
    bus1.op_a     = 1'b1;
    bus1.op_b     = 1'b1;
    bus1.sub      = 1'b0;
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    check("w1_busy_run", 32'(bus1.busy), 32'd1);
    check("w1_not_valid_yet", 32'(bus1.out_valid), 32'd0);
    tick();
    check("w1_valid", 32'(bus1.out_valid), 32'd1);
    check("w1_sum", 32'(bus1.sum), 32'd0);
    check("w1_cout", 32'(bus1.cout), 32'd1);
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    check("w1_idle", 32'(bus1.in_ready), 32'd1);
    bus1.op_a     = 1'b1;
    bus1.op_b     = 1'b0;
    bus1.sub      = 1'b0;
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    tick();
    check("w1_add10_valid", 32'(bus1.out_valid), 32'd1);
    check("w1_add10_sum", 32'(bus1.sum), 32'd1);
    check("w1_add10_cout", 32'(bus1.cout), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
